// File: rtl/recolor_pkg.sv
// Shared types and the per-requester replacement colour table for the recolor controller.
package recolor_pkg;

  typedef logic [7:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int NUM_REQ_MAX = 4;

  // Index order matches requester priority: red, yellow, green, blue.
  localparam rgb_t TO_COLOR [NUM_REQ_MAX] = '{8'hE0, 8'hFC, 8'h1C, 8'h03};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic rgb_t to_color(input int idx);
    return (idx < NUM_REQ_MAX) ? TO_COLOR[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/recolor_controller_prio_arbiter.sv
// Fixed-priority grant encoder: the lowest set bit of i_pending wins.
module prio_arbiter
  import recolor_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_pending,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    // Scan downward so the last hit is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_valid = 1'b1;
        o_index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/recolor_controller.sv
// Timed blinking recolor sequencer for the pixel pipeline; frame-counted, fixed-priority requesters.
// Optional preemption of a lower-priority effect is built when RECOLOR_PREEMPT_EN is defined.
module recolor_controller
  import recolor_pkg::*;
#(
  parameter int   NUM_REQ         = 4,
  parameter int   BLINK_FRAMES    = 8,
  parameter int   DURATION_FRAMES = 64,
  parameter int   GAP_FRAMES      = 4,
  parameter rgb_t CHANGE_FROM     = 8'hFF
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [NUM_REQ-1:0]         req,
  output logic                       enable,
  output logic [7:0]                 change_from,
  output logic [7:0]                 change_to,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max3(DURATION_FRAMES, BLINK_FRAMES, GAP_FRAMES) + 1);
  localparam logic [CW-1:0] DUR_LAST   = CW'(DURATION_FRAMES - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP_FRAMES == 0) ? '0 : CW'(GAP_FRAMES - 1);

  if (DURATION_FRAMES == 0 || BLINK_FRAMES == 0) begin : g_bad_frames
    $error("recolor_controller: DURATION_FRAMES and BLINK_FRAMES must be non-zero");
  end
  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("recolor_controller: NUM_REQ must be within 2..NUM_REQ_MAX");
  end

  state_t             r_state, w_state_nx;
  logic [NUM_REQ-1:0] r_pending, w_pending_nx;
  logic [CW-1:0]      r_dur_cnt, r_blink_cnt, r_gap_cnt;
  logic [CW-1:0]      w_dur_nx, w_blink_nx, w_gap_nx;
  logic               r_enable, r_busy, r_done;
  rgb_t               r_change_from, r_change_to;
  logic [IW-1:0]      r_active_id;

  logic               w_arb_valid;
  logic [IW-1:0]      w_arb_idx;
  logic               w_run, w_retrig, w_preempt, w_grant, w_done_nx;
  logic [NUM_REQ-1:0] w_act_mask, w_grant_mask;

  prio_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .i_pending (r_pending),
    .o_valid   (w_arb_valid),
    .o_index   (w_arb_idx)
  );

  assign w_run    = (r_state == ON) || (r_state == OFF);
  assign w_retrig = w_run && req[r_active_id];

`ifdef RECOLOR_PREEMPT_EN
  assign w_preempt = w_run && w_arb_valid && (w_arb_idx < r_active_id);
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_dur_nx   = r_dur_cnt;
    w_blink_nx = r_blink_cnt;
    w_gap_nx   = r_gap_cnt;
    w_grant    = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: w_grant = w_arb_valid;
      ON, OFF: begin
        if (w_preempt) begin
          w_grant = 1'b1;
        end else if (w_retrig) begin
          w_dur_nx   = '0;
          w_blink_nx = '0;
        end else if (startOfFrame) begin
          // Duration expiry outranks a blink toggle on the same frame.
          if (r_dur_cnt == DUR_LAST) begin
            w_state_nx = GAP;
            w_done_nx  = 1'b1;
            w_dur_nx   = '0;
            w_blink_nx = '0;
            w_gap_nx   = '0;
          end else begin
            w_dur_nx = r_dur_cnt + 1'b1;
            if (r_blink_cnt == BLINK_LAST) begin
              w_blink_nx = '0;
              w_state_nx = (r_state == ON) ? OFF : ON;
            end else begin
              w_blink_nx = r_blink_cnt + 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (GAP_FRAMES == 0) begin
          w_state_nx = IDLE;
        end else if (startOfFrame) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nx = IDLE;
            w_gap_nx   = '0;
          end else begin
            w_gap_nx = r_gap_cnt + 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_grant) begin
      w_state_nx = ON;
      w_dur_nx   = '0;
      w_blink_nx = '0;
      w_gap_nx   = '0;
    end
  end

  always_comb begin
    w_act_mask   = '0;
    w_grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_act_mask[i]   = (r_active_id == IW'(i));
      w_grant_mask[i] = w_grant && (w_arb_idx == IW'(i));
    end
  end

  // A req for the running id is a retrigger, not a new pending entry; a preempted id re-queues.
  assign w_pending_nx = (r_pending
                         | (req & ~(w_run ? w_act_mask : '0))
                         | (w_preempt ? w_act_mask : '0))
                        & ~w_grant_mask;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_pending     <= '0;
      r_dur_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_gap_cnt     <= '0;
      r_enable      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_change_from <= '0;
      r_change_to   <= '0;
      r_active_id   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_pending   <= w_pending_nx;
      r_dur_cnt   <= w_dur_nx;
      r_blink_cnt <= w_blink_nx;
      r_gap_cnt   <= w_gap_nx;
      r_enable    <= (w_state_nx == ON);
      r_busy      <= (w_state_nx != IDLE);
      r_done      <= w_done_nx;
      if (w_grant) begin
        r_active_id   <= w_arb_idx;
        r_change_from <= CHANGE_FROM;
        r_change_to   <= to_color(int'(w_arb_idx));
      end
    end
  end

  assign enable      = r_enable;
  assign busy        = r_busy;
  assign done        = r_done;
  assign change_from = r_change_from;
  assign change_to   = r_change_to;
  assign active_id   = r_active_id;

endmodule

// File: tb/tb_recolor_controller.sv
// Directed bench for recolor_controller with short frame timings (blink 2, duration 8, gap 2).
module tb_recolor_controller;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic [3:0] req;
  logic       enable;
  logic [7:0] change_from;
  logic [7:0] change_to;
  logic [1:0] active_id;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_miss = 0;
  logic [0:0] exp_q[$];

  recolor_controller #(
    .NUM_REQ         (4),
    .BLINK_FRAMES    (2),
    .DURATION_FRAMES (8),
    .GAP_FRAMES      (2),
    .CHANGE_FROM     (8'hFF)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .req          (req),
    .enable       (enable),
    .change_from  (change_from),
    .change_to    (change_to),
    .active_id    (active_id),
    .busy         (busy),
    .done         (done)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic frame();
    repeat (9) tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic run_until_done(output int nf);
    nf = -1;
    for (int f = 1; f <= 20 && nf < 0; f++) begin
      frame();
      if (done) nf = f;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nf;
    int n_pre;
    logic saw_en;
    logic [0:0] e;

    resetN = 1'b0;
    startOfFrame = 1'b0;
    req = '0;
    repeat (3) tick();
    chk("rst_enable", int'(enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_from", int'(change_from), 0);
    chk("rst_to", int'(change_to), 0);
    chk("rst_id", int'(active_id), 0);
    resetN = 1'b1;
    tick();

    // single request on id 2
    pulse_req(4'b0100);
    chk("t1_busy_latched", int'(busy), 0);
    tick();
    chk("t1_busy", int'(busy), 1);
    chk("t1_enable", int'(enable), 1);
    chk("t1_to", int'(change_to), 8'h1C);
    chk("t1_from", int'(change_from), 8'hFF);
    chk("t1_id", int'(active_id), 2);
    exp_q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    e = exp_q.pop_front();
    chk("t1_blink_f0", int'(enable), int'(e));
    for (int k = 1; k < 8; k++) begin
      frame();
      e = exp_q.pop_front();
      chk($sformatf("t1_blink_f%0d", k), int'(enable), int'(e));
      chk($sformatf("t1_nodone_f%0d", k), int'(done), 0);
    end
    frame();
    chk("t1_done", int'(done), 1);
    chk("t1_done_enable", int'(enable), 0);
    chk("t1_gap_busy", int'(busy), 1);
    tick();
    chk("t1_done_pulse", int'(done), 0);
    frame();
    chk("t1_gap1_busy", int'(busy), 1);
    frame();
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_to_hold", int'(change_to), 8'h1C);
    chk("t1_idle_id_hold", int'(active_id), 2);

    // priority: ids 1 and 3 together, 1 first, then 3 after the gap
    pulse_req(4'b1010);
    tick();
    chk("t2_first_id", int'(active_id), 1);
    chk("t2_first_to", int'(change_to), 8'hFC);
    run_until_done(nf);
    chk("t2_first_len", nf, 8);
    saw_en = 1'b0;
    repeat (2) begin
      repeat (9) begin
        tick();
        saw_en |= enable;
      end
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      saw_en |= enable;
    end
    chk("t2_gap_enable", int'(saw_en), 0);
    chk("t2_gap_idle", int'(busy), 0);
    // req[3] lands on the very clk that grants the queued id 3
    req = 4'b1000;
    tick();
    req = '0;
    chk("t2_second_id", int'(active_id), 3);
    chk("t2_second_to", int'(change_to), 8'h03);
    run_until_done(nf);
    chk("t2_second_len", nf, 8);
    frame();
    frame();
    repeat (5) tick();
    chk("t2_no_regrant", int'(busy), 0);

    // retrigger of id 1 after frame 5
    pulse_req(4'b0010);
    tick();
    chk("t3_id", int'(active_id), 1);
    n_pre = 0;
    repeat (5) begin
      frame();
      if (done) n_pre++;
    end
    pulse_req(4'b0010);
    run_until_done(nf);
    chk("t3_no_early_done", n_pre, 0);
    chk("t3_done_frame", 5 + nf, 13);
    frame();
    frame();

    // retrigger of id 0 on the exact clk of duration expiry
    pulse_req(4'b0001);
    tick();
    chk("t4_id", int'(active_id), 0);
    repeat (7) frame();
    repeat (9) tick();
    startOfFrame = 1'b1;
    req = 4'b0001;
    tick();
    startOfFrame = 1'b0;
    req = '0;
    chk("t4_no_done", int'(done), 0);
    chk("t4_still_busy", int'(busy), 1);
    run_until_done(nf);
    chk("t4_restart_len", nf, 8);
    frame();
    frame();

    // reset while in OFF with another id pending
    pulse_req(4'b0100);
    tick();
    frame();
    frame();
    chk("t5_off_enable", int'(enable), 0);
    chk("t5_off_busy", int'(busy), 1);
    pulse_req(4'b1000);
    resetN = 1'b0;
    #1;
    chk("t5_rst_enable", int'(enable), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_to", int'(change_to), 0);
    tick();
    resetN = 1'b1;
    repeat (3) frame();
    chk("t5_pending_lost", int'(busy), 0);
    chk("t5_id", int'(active_id), 0);

    // higher-priority request while id 3 runs
    pulse_req(4'b1000);
    tick();
    chk("t6_id3", int'(active_id), 3);
    frame();
    frame();
    pulse_req(4'b0001);
    tick();
`ifdef RECOLOR_PREEMPT_EN
    chk("t6_preempt_id", int'(active_id), 0);
    chk("t6_preempt_to", int'(change_to), 8'hE0);
    chk("t6_preempt_nodone", int'(done), 0);
    chk("t6_preempt_enable", int'(enable), 1);
    run_until_done(nf);
    chk("t6_len0", nf, 8);
    frame();
    frame();
    tick();
    chk("t6_resume_id", int'(active_id), 3);
    chk("t6_resume_to", int'(change_to), 8'h03);
`else
    chk("t6_keep_id", int'(active_id), 3);
    chk("t6_keep_to", int'(change_to), 8'h03);
    run_until_done(nf);
    chk("t6_len3", nf, 6);
    chk("t6_done_id", int'(active_id), 3);
    frame();
    frame();
    tick();
    chk("t6_next_id", int'(active_id), 0);
    chk("t6_next_to", int'(change_to), 8'hE0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
